// File: rtl/dtc_ctrl_pkg.sv
// DTC controller shared definitions.
// Default widths and the FCW bundle type.
package dtc_ctrl_pkg;

  localparam int FRAC_W   = 16;
  localparam int DCW_W    = 10;
  localparam int KDTC_W   = 12;
  localparam int DIVN_RST = 8;

  // KDTC is Q1.11 and DCW is acc >> 6, so the product is scaled by 2^17.
  localparam int GAIN_SH  = 17;

  typedef struct packed {
    logic [7:0]        i;
    logic [FRAC_W-1:0] f;
  } fcw_t;

endpackage

// File: rtl/dtc_ctrl_gain.sv
// DTC gain stage: scales the accumulator by KDTC.
// Saturates the result to the DCW range.
module dtc_ctrl_gain #(
  parameter int FRAC_W = dtc_ctrl_pkg::FRAC_W,
  parameter int DCW_W  = dtc_ctrl_pkg::DCW_W,
  parameter int KDTC_W = dtc_ctrl_pkg::KDTC_W
) (
  input  logic [FRAC_W-1:0] i_acc,
  input  logic [KDTC_W-1:0] i_kdtc,
  output logic [DCW_W-1:0]  o_dcw,
  output logic              o_sat
);
  import dtc_ctrl_pkg::*;

  localparam int PW = FRAC_W + KDTC_W;
  localparam logic [PW-1:0] DCW_MAX = PW'((1 << DCW_W) - 1);

  logic [PW-1:0] w_prod;
  logic [PW-1:0] w_raw;

  assign w_prod = PW'(i_acc) * PW'(i_kdtc);
  assign w_raw  = w_prod >> GAIN_SH;
  assign o_sat  = (w_raw > DCW_MAX);
  assign o_dcw  = o_sat ? DCW_MAX[DCW_W-1:0]
                        : w_raw[DCW_W-1:0];

endmodule

// File: rtl/dtc_ctrl.sv
// Fractional-N DTC controller: FCW shadowing,
// phase accumulator and DIV_N/DCW output pipeline.
module dtc_ctrl #(
  parameter int FRAC_W   = dtc_ctrl_pkg::FRAC_W,
  parameter int DCW_W    = dtc_ctrl_pkg::DCW_W,
  parameter int KDTC_W   = dtc_ctrl_pkg::KDTC_W,
  parameter int DIVN_RST = dtc_ctrl_pkg::DIVN_RST
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic [7:0]        FCW_I,
  input  logic [FRAC_W-1:0] FCW_F,
  input  logic              FCW_LD,
  input  logic [KDTC_W-1:0] KDTC,
  output logic [7:0]        DIV_N,
  output logic [DCW_W-1:0]  DCW,
  output logic              FCW_ACK,
  output logic              OVF
);
  import dtc_ctrl_pkg::*;

  localparam logic [7:0] DIVN_INIT = 8'(DIVN_RST);

  fcw_t              r_act;
  fcw_t              r_shd;
  logic              r_pend;
  logic [FRAC_W-1:0] r_acc;
  logic              r_carry;
  logic              r_v1;
  logic [7:0]        r_divn;
  logic [DCW_W-1:0]  r_dcw;
  logic              r_ack;
  logic              r_ovf;

  logic              w_apply;
  logic [FRAC_W-1:0] w_f;
  logic [FRAC_W:0]   w_sum;
  logic [DCW_W-1:0]  w_dcw;
  logic              w_sat;

  // A load on the same edge keeps the shadow pending.
  assign w_apply = EN & r_pend & ~FCW_LD;
  assign w_f     = w_apply ? r_shd.f : r_act.f;
  assign w_sum   = {1'b0, r_acc} + {1'b0, w_f};

  dtc_ctrl_gain #(
    .FRAC_W (FRAC_W),
    .DCW_W  (DCW_W),
    .KDTC_W (KDTC_W)
  ) u_gain (
    .i_acc  (r_acc),
    .i_kdtc (KDTC),
    .o_dcw  (w_dcw),
    .o_sat  (w_sat)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_act   <= '{i: DIVN_INIT, f: '0};
      r_shd   <= '{i: DIVN_INIT, f: '0};
      r_pend  <= 1'b0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_v1    <= 1'b0;
      r_divn  <= DIVN_INIT;
      r_dcw   <= '0;
      r_ack   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_ack <= w_apply;
      if (FCW_LD) begin
        r_shd  <= '{i: FCW_I, f: FCW_F};
        r_pend <= 1'b1;
      end
      if (EN) begin
        {r_carry, r_acc} <= w_sum;
      end
      if (w_apply) begin
        r_act  <= r_shd;
        r_pend <= 1'b0;
      end
      // Stage 2 follows every stage-1 step by exactly one edge.
      r_v1 <= EN;
      if (r_v1) begin
        r_divn <= r_act.i + 8'(r_carry);
        r_dcw  <= w_dcw;
      end
      if (r_v1 && w_sat) begin
        r_ovf <= 1'b1;
      end else if (w_apply) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign DIV_N   = r_divn;
  assign DCW     = r_dcw;
  assign FCW_ACK = r_ack;
  assign OVF     = r_ovf;

endmodule

// File: tb/tb_dtc_ctrl.sv
// Directed and random bench for dtc_ctrl with
// an arithmetic reference model.
module tb_dtc_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        EN = 1'b0;
  logic [7:0]  FCW_I = 8'd0;
  logic [15:0] FCW_F = 16'd0;
  logic        FCW_LD = 1'b0;
  logic [11:0] KDTC = 12'd2048;
  logic [7:0]  DIV_N;
  logic [9:0]  DCW;
  logic        FCW_ACK;
  logic        OVF;

  int tests = 0;
  int fails = 0;

  dtc_ctrl dut (
    .CLK     (CLK),
    .RST     (RST),
    .EN      (EN),
    .FCW_I   (FCW_I),
    .FCW_F   (FCW_F),
    .FCW_LD  (FCW_LD),
    .KDTC    (KDTC),
    .DIV_N   (DIV_N),
    .DCW     (DCW),
    .FCW_ACK (FCW_ACK),
    .OVF     (OVF)
  );

  always #5 CLK = ~CLK;

  // Reference state: configured FCW, a pending shadow,
  // phase value, and the accumulator step awaiting output.
  int m_act_i, m_act_f, m_shd_i, m_shd_f;
  bit m_pend;
  int m_acc;
  bit m_step;
  int m_step_acc, m_step_div;
  int e_div, e_dcw;
  bit e_ack, e_ovf;

  function automatic void m_reset();
    m_act_i = 8; m_act_f = 0;
    m_shd_i = 8; m_shd_f = 0;
    m_pend = 0; m_acc = 0; m_step = 0;
    e_div = 8; e_dcw = 0; e_ack = 0; e_ovf = 0;
  endfunction

  // One rising edge, from the inputs held across it.
  function automatic void m_edge(bit en, bit ld, int fi,
                                 int ff, int k);
    bit app;
    bit sat;
    int raw;
    int total;
    sat = 0;
    if (m_step) begin
      e_div = m_step_div;
      raw = (m_step_acc * k) / 131072;
      sat = raw > 1023;
      e_dcw = sat ? 1023 : raw;
    end
    app = en && m_pend && !ld;
    if (app) e_ovf = 0;
    if (sat) e_ovf = 1;
    e_ack = app;
    if (en) begin
      if (app) begin
        m_act_i = m_shd_i;
        m_act_f = m_shd_f;
        m_pend = 0;
      end
      total = m_acc + m_act_f;
      m_acc = total % 65536;
      m_step_acc = m_acc;
      m_step_div = (m_act_i + total / 65536) % 256;
    end
    if (ld) begin
      m_shd_i = fi;
      m_shd_f = ff;
      m_pend = 1;
    end
    m_step = en;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".div_n"}, 32'(DIV_N), 32'(e_div));
    chk({tag, ".dcw"}, 32'(DCW), 32'(e_dcw));
    chk({tag, ".ack"}, 32'(FCW_ACK), 32'(e_ack));
    chk({tag, ".ovf"}, 32'(OVF), 32'(e_ovf));
  endtask

  task automatic step(input bit en, input bit ld,
                      input int fi, input int ff);
    @(negedge CLK);
    EN = en;
    FCW_LD = ld;
    FCW_I = 8'(fi);
    FCW_F = 16'(ff);
    @(posedge CLK);
    m_edge(en, ld, fi, ff, int'(KDTC));
    #1;
    chk_all("step");
  endtask

  task automatic async_reset(input string tag);
    #3;
    RST = 1'b1;
    #1;
    m_reset();
    chk_all(tag);
    @(posedge CLK);
    @(negedge CLK);
    EN = 1'b0;
    FCW_LD = 1'b0;
    RST = 1'b0;
  endtask

  int sw_dcw [4] = '{256, 512, 768, 0};
  int sw_div [4] = '{10, 10, 10, 11};
  int acks;

  initial begin
    m_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk_all("reset");
    @(negedge CLK);
    RST = 1'b0;

    // Fractional sweep at unity gain.
    KDTC = 12'd2048;
    step(0, 1, 10, 16'h4000);
    step(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 0, 0);
      chk("sweep.dcw", 32'(DCW), 32'(sw_dcw[i % 4]));
      chk("sweep.div", 32'(DIV_N), 32'(sw_div[i % 4]));
    end

    // Saturation at maximum gain stays sticky.
    KDTC = 12'd4095;
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    chk("sat.ovf", 32'(OVF), 32'd1);
    KDTC = 12'd2048;
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    chk("sat.sticky", 32'(OVF), 32'd1);

    // Back-to-back loads: last one wins, single ACK.
    acks = 0;
    step(1, 1, 10, 16'h1000);
    acks += int'(FCW_ACK);
    step(1, 1, 10, 16'h2000);
    acks += int'(FCW_ACK);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0);
      acks += int'(FCW_ACK);
    end
    chk("ld.acks", 32'(acks), 32'd1);
    chk("ld.ovf_clr", 32'(OVF), 32'd0);

    // Enable hold with a load captured during the hold.
    step(0, 0, 0, 0);
    step(0, 1, 12, 16'h3000);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0);

    // Reset while a load is pending.
    step(1, 1, 20, 16'h8000);
    async_reset("rst_mid");
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    chk("rst.no_ack", 32'(FCW_ACK), 32'd0);
    chk("rst.div_n", 32'(DIV_N), 32'd8);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0)
        KDTC = 12'($urandom);
      step($urandom_range(0, 3) != 0,
           $urandom_range(0, 9) == 0,
           int'($urandom_range(0, 255)),
           int'($urandom_range(0, 65535)));
      if (i == 200) async_reset("rst_rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
